// File: rtl/id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipeline_reg
// Purpose  : ID/EX pipeline register. Loads decoded operands and controls,
//            turns a hazard-unit bubble or a branch flush into a NOP in EX,
//            holds on ex_busy / stall, and counts bubble and flush cycles
//            with saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipeline_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             ex_busy,
  input  logic             stall,
  input  logic             bubble,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_data1,
  input  logic [XLEN-1:0]  id_data2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_alu_op,
  input  logic [2:0]       id_funct3,
  input  logic [4:0]       id_ctrl,
  input  logic [1:0]       id_fwd1sel,
  input  logic [1:0]       id_fwd2sel,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_data1,
  output logic [XLEN-1:0]  ex_data2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_alu_op,
  output logic [2:0]       ex_funct3,
  output logic [4:0]       ex_ctrl,
  output logic [1:0]       ex_fwd1sel,
  output logic [1:0]       ex_fwd2sel,
  output logic             ex_valid,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_data1;
  logic [XLEN-1:0]  r_data2;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rd;
  logic [4:0]       r_alu_op;
  logic [2:0]       r_funct3;
  logic [4:0]       r_ctrl;
  logic [1:0]       r_fwd1sel;
  logic [1:0]       r_fwd2sel;
  logic             r_valid;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Action decode in priority order: flush > ex_busy > bubble > stall > load.
  // A NOP load zeroes every field so nothing from ID (even X) reaches EX.
  logic w_nop;
  logic w_load;
  logic w_bubble_inc;
  logic w_flush_inc;

  // Combinational action selection; exactly one of nop/load/hold per edge.
  always_comb begin
    w_flush_inc  = flush;
    w_bubble_inc = !flush && !ex_busy && bubble;
    w_nop        = w_flush_inc || w_bubble_inc;
    w_load       = !flush && !ex_busy && !bubble && !stall;
  end

  // Pipeline payload register: NOP-load, load from ID, or hold.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc      <= '0;
      r_data1   <= '0;
      r_data2   <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_alu_op  <= '0;
      r_funct3  <= '0;
      r_ctrl    <= '0;
      r_fwd1sel <= '0;
      r_fwd2sel <= '0;
      r_valid   <= 1'b0;
    end else if (w_nop) begin
      r_pc      <= '0;
      r_data1   <= '0;
      r_data2   <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_alu_op  <= '0;
      r_funct3  <= '0;
      r_ctrl    <= '0;
      r_fwd1sel <= '0;
      r_fwd2sel <= '0;
      r_valid   <= 1'b0;
    end else if (w_load) begin
      r_pc      <= id_pc;
      r_data1   <= id_data1;
      r_data2   <= id_data2;
      r_imm     <= id_imm;
      r_rd      <= id_rd;
      r_alu_op  <= id_alu_op;
      r_funct3  <= id_funct3;
      r_ctrl    <= id_ctrl;
      r_fwd1sel <= id_fwd1sel;
      r_fwd2sel <= id_fwd2sel;
      r_valid   <= 1'b1;
    end
  end

  // Saturating performance counters; only reset clears them.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_bubble_inc && (r_bubble_cnt != c_CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
      if (w_flush_inc && (r_flush_cnt != c_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign ex_pc      = r_pc;
  assign ex_data1   = r_data1;
  assign ex_data2   = r_data2;
  assign ex_imm     = r_imm;
  assign ex_rd      = r_rd;
  assign ex_alu_op  = r_alu_op;
  assign ex_funct3  = r_funct3;
  assign ex_ctrl    = r_ctrl;
  assign ex_fwd1sel = r_fwd1sel;
  assign ex_fwd2sel = r_fwd2sel;
  assign ex_valid   = r_valid;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipeline_reg
// Purpose  : Self-checking bench for id_ex_pipeline_reg: directed scenarios
//            followed by random control/data traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipeline_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int PW    = 4*XLEN + 5 + 5 + 3 + 5 + 2 + 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RESET, flush, ex_busy, stall, bubble;
  logic [XLEN-1:0] id_pc, id_data1, id_data2, id_imm;
  logic [4:0] id_rd, id_alu_op, id_ctrl;
  logic [2:0] id_funct3;
  logic [1:0] id_fwd1sel, id_fwd2sel;
  logic [XLEN-1:0] ex_pc, ex_data1, ex_data2, ex_imm;
  logic [4:0] ex_rd, ex_alu_op, ex_ctrl;
  logic [2:0] ex_funct3;
  logic [1:0] ex_fwd1sel, ex_fwd2sel;
  logic ex_valid;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: what EX should contain and how many events occurred.
  logic [PW-1:0] m_pay;
  logic          m_valid;
  int            m_bubbles;
  int            m_flushes;

  always #5 CLK = ~CLK;

  id_ex_pipeline_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush), .ex_busy(ex_busy), .stall(stall),
    .bubble(bubble), .id_pc(id_pc), .id_data1(id_data1), .id_data2(id_data2),
    .id_imm(id_imm), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
    .id_ctrl(id_ctrl), .id_fwd1sel(id_fwd1sel), .id_fwd2sel(id_fwd2sel),
    .ex_pc(ex_pc), .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_ctrl(ex_ctrl),
    .ex_fwd1sel(ex_fwd1sel), .ex_fwd2sel(ex_fwd2sel), .ex_valid(ex_valid),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [PW-1:0] id_bundle();
    return {id_pc, id_data1, id_data2, id_imm, id_rd, id_alu_op, id_funct3,
            id_ctrl, id_fwd1sel, id_fwd2sel};
  endfunction

  function automatic logic [PW-1:0] ex_bundle();
    return {ex_pc, ex_data1, ex_data2, ex_imm, ex_rd, ex_alu_op, ex_funct3,
            ex_ctrl, ex_fwd1sel, ex_fwd2sel};
  endfunction

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic rand_id();
    id_pc      = $urandom;
    id_data1   = $urandom;
    id_data2   = $urandom;
    id_imm     = $urandom;
    id_rd      = 5'($urandom);
    id_alu_op  = 5'($urandom);
    id_funct3  = 3'($urandom);
    id_ctrl    = 5'($urandom);
    id_fwd1sel = 2'($urandom);
    id_fwd2sel = 2'($urandom);
  endtask

  // Apply controls (with fresh random ID data) away from the active edge.
  task automatic drive(input logic f, input logic b, input logic s, input logic bb);
    @(negedge CLK);
    flush = f; ex_busy = b; stall = s; bubble = bb;
    rand_id();
  endtask

  task automatic model_reset();
    m_pay = '0; m_valid = 1'b0; m_bubbles = 0; m_flushes = 0;
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (ex_bundle() === m_pay) else begin
      failures++;
      $error("FAIL %s payload: observed=%h expected=%h", tag, ex_bundle(), m_pay);
    end
    checks++;
    assert (ex_valid === m_valid) else begin
      failures++;
      $error("FAIL %s ex_valid: observed=%b expected=%b", tag, ex_valid, m_valid);
    end
    checks++;
    assert (bubble_cnt === CNT_W'(sat(m_bubbles))) else begin
      failures++;
      $error("FAIL %s bubble_cnt: observed=%0d expected=%0d", tag, bubble_cnt, sat(m_bubbles));
    end
    checks++;
    assert (flush_cnt === CNT_W'(sat(m_flushes))) else begin
      failures++;
      $error("FAIL %s flush_cnt: observed=%0d expected=%0d", tag, flush_cnt, sat(m_flushes));
    end
  endtask

  // One clock edge: update the model from the documented priority rules, then check.
  task automatic tick(input string tag);
    logic [PW-1:0] idb;
    idb = id_bundle();
    @(posedge CLK);
    if (flush) begin
      m_pay = '0; m_valid = 1'b0; m_flushes++;
    end else if (ex_busy) begin
      // hold
    end else if (bubble) begin
      m_pay = '0; m_valid = 1'b0; m_bubbles++;
    end else if (!stall) begin
      m_pay = idb; m_valid = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // 1: reset with random ID data
    RESET = 1'b1; flush = 0; ex_busy = 0; stall = 0; bubble = 0;
    rand_id();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    drive(0, 0, 0, 0);
    RESET = 1'b0;
    id_rd = 5'd5; id_ctrl = 5'b10000;
    tick("first_load");
    checks++;
    assert (ex_rd === 5'd5 && ex_ctrl === 5'b10000 && ex_valid === 1'b1) else begin
      failures++;
      $error("FAIL first_load_fields: observed rd=%0d ctrl=%b v=%b expected rd=5 ctrl=10000 v=1",
             ex_rd, ex_ctrl, ex_valid);
    end

    // 2: load-use bubble then dependent instruction
    drive(0, 0, 0, 0); id_rd = 5'd7; id_ctrl = 5'b11000;
    tick("load_x7");
    drive(0, 0, 1, 1);
    tick("load_use_bubble");
    checks++;
    assert (ex_valid === 1'b0 && ex_ctrl === 5'b0 && bubble_cnt === CNT_W'(1)) else begin
      failures++;
      $error("FAIL bubble_nop: observed v=%b ctrl=%b bc=%0d expected v=0 ctrl=0 bc=1",
             ex_valid, ex_ctrl, bubble_cnt);
    end
    drive(0, 0, 0, 0);
    tick("dependent_load");

    // 3: ex_busy hold for 33 cycles with changing ID data
    for (int i = 0; i < 33; i++) begin
      drive(0, 1, i[0], i[1]);
      tick("busy_hold");
    end
    drive(0, 0, 0, 0);
    tick("busy_release");

    // 4: flush beats busy and bubble
    drive(1, 1, 1, 1);
    tick("flush_priority");

    // 5: bubble counter saturation
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 1);
      tick("bubble_sat");
    end
    checks++;
    assert (bubble_cnt === 4'hF) else begin
      failures++;
      $error("FAIL bubble_saturate: observed=%h expected=F", bubble_cnt);
    end

    // 6: stall-only hold after a load
    drive(0, 0, 0, 0);
    tick("pre_stall_load");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      tick("stall_hold");
    end

    // Async reset mid-busy, then priority resumes on first edge
    drive(0, 1, 0, 0);
    tick("busy_before_reset");
    #2 RESET = 1'b1;
    model_reset();
    #1;
    check_all("async_reset_mid_busy");
    drive(0, 0, 0, 0);
    RESET = 1'b0;
    tick("after_reset_load");

    // Flush counter saturation
    for (int i = 0; i < 18; i++) begin
      drive(1, 0, 0, 0);
      tick("flush_sat");
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench cannot run away.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
